// File: rtl/gray_mult_sched.sv
// gray_mult_sched: front-end sequencer for the RGB-to-grey fixed-constant
// multiplier. It normalises each 8-bit channel into a {1,8} fraction plus a
// pixel exponent and runs the multiplier once per pixel. The multiplier
// result is captured on the rising edge of its done level, the pixel
// exponent is folded into the result exponent, and one beat is presented
// downstream. A watchdog aborts a run whose done edge never arrives.
module gray_mult_sched #(
  parameter int PIXEL_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk_i_fix_multi,
  input  logic                   rstn_i_fix_multi,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  input  logic [PIXEL_WIDTH-1:0] pix_r_i,
  input  logic [PIXEL_WIDTH-1:0] pix_g_i,
  input  logic [PIXEL_WIDTH-1:0] pix_b_i,
  output logic                   mult_en_o,
  output logic [9:0]             mult_data_r_o,
  output logic [9:0]             mult_data_g_o,
  output logic [9:0]             mult_data_b_o,
  input  logic [9:0]             mult_res_r_i,
  input  logic [9:0]             mult_res_g_i,
  input  logic [9:0]             mult_res_b_i,
  input  logic signed [4:0]      mult_exp_r_i,
  input  logic signed [4:0]      mult_exp_g_i,
  input  logic signed [4:0]      mult_exp_b_i,
  input  logic                   mult_done_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [9:0]             out_frac_r_o,
  output logic [9:0]             out_frac_g_o,
  output logic [9:0]             out_frac_b_o,
  output logic signed [5:0]      out_exp_r_o,
  output logic signed [5:0]      out_exp_g_o,
  output logic signed [5:0]      out_exp_b_o,
  output logic [2:0]             out_zero_o,
  output logic                   err_o
);

  localparam int PEXP_W = $clog2(PIXEL_WIDTH);
  localparam int FRAC_W = PIXEL_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  typedef struct packed {
    logic              zero;
    logic [PEXP_W-1:0] pexp;
    logic [FRAC_W-1:0] frac;
  } norm_t;

  // Shift the leading one up to the fraction MSB; the shift count gives the
  // pixel exponent. A zero pixel has no leading one and is flagged instead.
  function automatic norm_t normalise(input logic [PIXEL_WIDTH-1:0] pix);
    norm_t                  n;
    logic [PEXP_W-1:0]      p;
    logic [PIXEL_WIDTH-1:0] sh;
    p = '0;
    for (int i = 0; i < PIXEL_WIDTH; i++) begin
      if (pix[i]) p = PEXP_W'(i);
    end
    sh = pix << (PEXP_W'(PIXEL_WIDTH - 1) - p);
    if (pix == '0) begin
      n.zero = 1'b1;
      n.pexp = '0;
      n.frac = '0;
    end else begin
      n.zero = 1'b0;
      n.pexp = p;
      n.frac = {sh, 2'b00};
    end
    return n;
  endfunction

  // Result exponent plus the non-negative pixel exponent; 6 signed bits
  // cover [-16,22] so no saturation is needed.
  function automatic logic signed [5:0] fold_exp(input logic signed [4:0] e,
                                                 input logic [PEXP_W-1:0] p);
    logic signed [5:0] es;
    logic signed [5:0] ps;
    es = 6'(e);
    ps = $signed({{(6-PEXP_W){1'b0}}, p});
    return es + ps;
  endfunction

  norm_t norm_r, norm_g, norm_b;

  assign norm_r = normalise(pix_r_i);
  assign norm_g = normalise(pix_g_i);
  assign norm_b = normalise(pix_b_i);

  state_t               state;
  logic                 done_q;
  logic                 done_pulse;
  logic [CNT_WIDTH-1:0] wd_cnt;
  logic [PEXP_W-1:0]    pexp_r_p0, pexp_g_p0, pexp_b_p0;
  logic [2:0]           zero_p0;

  assign done_pulse = mult_done_i & ~done_q;

  // Delay the done level by one cycle so only its rising edge is acted on.
  always_ff @(posedge clk_i_fix_multi or posedge rstn_i_fix_multi) begin
    if (rstn_i_fix_multi) done_q <= 1'b0;
    else                  done_q <= mult_done_i;
  end

  // Sequencer: accept a pixel, run the multiplier, present one result beat.
  always_ff @(posedge clk_i_fix_multi or posedge rstn_i_fix_multi) begin
    if (rstn_i_fix_multi) begin
      state         <= IDLE;
      pix_ready_o   <= 1'b0;
      mult_en_o     <= 1'b0;
      mult_data_r_o <= '0;
      mult_data_g_o <= '0;
      mult_data_b_o <= '0;
      pexp_r_p0     <= '0;
      pexp_g_p0     <= '0;
      pexp_b_p0     <= '0;
      zero_p0       <= '0;
      wd_cnt        <= '0;
      out_valid_o   <= 1'b0;
      out_frac_r_o  <= '0;
      out_frac_g_o  <= '0;
      out_frac_b_o  <= '0;
      out_exp_r_o   <= '0;
      out_exp_g_o   <= '0;
      out_exp_b_o   <= '0;
      out_zero_o    <= '0;
      err_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pix_ready_o <= 1'b1;
          if (pix_valid_i && pix_ready_o) begin
            // stage p0: normalised operands, held for the whole run
            mult_data_r_o <= norm_r.frac;
            mult_data_g_o <= norm_g.frac;
            mult_data_b_o <= norm_b.frac;
            pexp_r_p0     <= norm_r.pexp;
            pexp_g_p0     <= norm_g.pexp;
            pexp_b_p0     <= norm_b.pexp;
            zero_p0       <= {norm_r.zero, norm_g.zero, norm_b.zero};
            mult_en_o     <= 1'b1;
            wd_cnt        <= '0;
            pix_ready_o   <= 1'b0;
            state         <= RUN;
          end
        end
        RUN: begin
          if (done_pulse) begin
            // stage p1: captured results with the pixel exponent folded in
            mult_en_o    <= 1'b0;
            out_frac_r_o <= zero_p0[2] ? 10'd0 : mult_res_r_i;
            out_frac_g_o <= zero_p0[1] ? 10'd0 : mult_res_g_i;
            out_frac_b_o <= zero_p0[0] ? 10'd0 : mult_res_b_i;
            out_exp_r_o  <= zero_p0[2] ? 6'sd0 : fold_exp(mult_exp_r_i, pexp_r_p0);
            out_exp_g_o  <= zero_p0[1] ? 6'sd0 : fold_exp(mult_exp_g_i, pexp_g_p0);
            out_exp_b_o  <= zero_p0[0] ? 6'sd0 : fold_exp(mult_exp_b_i, pexp_b_p0);
            out_zero_o   <= zero_p0;
            out_valid_o  <= 1'b1;
            state        <= OUT;
          end else if (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            mult_en_o   <= 1'b0;
            err_o       <= 1'b1;
            wd_cnt      <= '0;
            pix_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            pix_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_mult_sched.sv
// Directed bench for gray_mult_sched. The bench plays the multiplier,
// predicts each result beat when the pixel is driven and compares it when
// the beat appears.
module tb_gray_mult_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid_i;
  logic              pix_ready_o;
  logic [7:0]        pix_r_i, pix_g_i, pix_b_i;
  logic              mult_en_o;
  logic [9:0]        mult_data_r_o, mult_data_g_o, mult_data_b_o;
  logic [9:0]        mult_res_r_i, mult_res_g_i, mult_res_b_i;
  logic signed [4:0] mult_exp_r_i, mult_exp_g_i, mult_exp_b_i;
  logic              mult_done_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [9:0]        out_frac_r_o, out_frac_g_o, out_frac_b_o;
  logic signed [5:0] out_exp_r_o, out_exp_g_o, out_exp_b_o;
  logic [2:0]        out_zero_o;
  logic              err_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]        fr, fg, fb;
    logic signed [5:0] er, eg, eb;
    logic [2:0]        z;
  } beat_t;

  beat_t sb_q[$];
  beat_t last;

  gray_mult_sched dut (
    .clk_i_fix_multi (clk),
    .rstn_i_fix_multi(rst),
    .pix_valid_i     (pix_valid_i),
    .pix_ready_o     (pix_ready_o),
    .pix_r_i         (pix_r_i),
    .pix_g_i         (pix_g_i),
    .pix_b_i         (pix_b_i),
    .mult_en_o       (mult_en_o),
    .mult_data_r_o   (mult_data_r_o),
    .mult_data_g_o   (mult_data_g_o),
    .mult_data_b_o   (mult_data_b_o),
    .mult_res_r_i    (mult_res_r_i),
    .mult_res_g_i    (mult_res_g_i),
    .mult_res_b_i    (mult_res_b_i),
    .mult_exp_r_i    (mult_exp_r_i),
    .mult_exp_g_i    (mult_exp_g_i),
    .mult_exp_b_i    (mult_exp_b_i),
    .mult_done_i     (mult_done_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_frac_r_o    (out_frac_r_o),
    .out_frac_g_o    (out_frac_g_o),
    .out_frac_b_o    (out_frac_b_o),
    .out_exp_r_o     (out_exp_r_o),
    .out_exp_g_o     (out_exp_g_o),
    .out_exp_b_o     (out_exp_b_o),
    .out_zero_o      (out_zero_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed running, required finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: position of the most significant set bit.
  function automatic int m_p(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [9:0] m_frac(input logic [7:0] v);
    if (v == 8'd0) return 10'd0;
    return 10'((int'(v) * (1 << (7 - m_p(v)))) * 4);
  endfunction

  function automatic logic signed [5:0] m_exp(input logic [7:0] v, input logic signed [4:0] e);
    if (v == 8'd0) return 6'sd0;
    return 6'(int'(e) + m_p(v));
  endfunction

  task automatic drive_pixel(input logic [7:0] r, g, b,
                             input logic [9:0] rr, rg, rb,
                             input logic signed [4:0] er, eg, eb,
                             input bit push);
    beat_t x;
    for (int i = 0; i < 20 && !pix_ready_o; i++) @(negedge clk);
    chk("pix_ready_before_send", pix_ready_o, 1'b1);
    pix_r_i = r; pix_g_i = g; pix_b_i = b;
    mult_res_r_i = rr; mult_res_g_i = rg; mult_res_b_i = rb;
    mult_exp_r_i = er; mult_exp_g_i = eg; mult_exp_b_i = eb;
    pix_valid_i = 1'b1;
    if (push) begin
      x.fr = (r == 8'd0) ? 10'd0 : rr;
      x.fg = (g == 8'd0) ? 10'd0 : rg;
      x.fb = (b == 8'd0) ? 10'd0 : rb;
      x.er = m_exp(r, er);
      x.eg = m_exp(g, eg);
      x.eb = m_exp(b, eb);
      x.z  = {r == 8'd0, g == 8'd0, b == 8'd0};
      sb_q.push_back(x);
    end
    @(negedge clk);
    pix_valid_i = 1'b0;
    chk("mult_en_after_accept", mult_en_o, 1'b1);
    chk("pix_ready_after_accept", pix_ready_o, 1'b0);
    chk("mult_data_r", mult_data_r_o, m_frac(r));
    chk("mult_data_g", mult_data_g_o, m_frac(g));
    chk("mult_data_b", mult_data_b_o, m_frac(b));
  endtask

  task automatic pulse_done(input int n);
    mult_done_i = 1'b0;
    repeat (n) @(negedge clk);
    chk("mult_en_before_done", mult_en_o, 1'b1);
    chk("no_early_out_valid", out_valid_o, 1'b0);
    mult_done_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic expect_beat(input string tag);
    for (int i = 0; i < 20 && !out_valid_o; i++) @(negedge clk);
    chk({tag, "_out_valid"}, out_valid_o, 1'b1);
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      last = sb_q.pop_front();
      chk({tag, "_frac_r"}, out_frac_r_o, last.fr);
      chk({tag, "_frac_g"}, out_frac_g_o, last.fg);
      chk({tag, "_frac_b"}, out_frac_b_o, last.fb);
      chk({tag, "_exp_r"}, out_exp_r_o, last.er);
      chk({tag, "_exp_g"}, out_exp_g_o, last.eg);
      chk({tag, "_exp_b"}, out_exp_b_o, last.eb);
      chk({tag, "_zero"}, out_zero_o, last.z);
      chk({tag, "_mult_en_off"}, mult_en_o, 1'b0);
    end
  endtask

  // Hold the beat for 'stall' cycles while disturbing the multiplier inputs,
  // then accept it.
  task automatic finish_beat(input string tag, input int stall);
    repeat (stall) begin
      mult_res_r_i = ~mult_res_r_i;
      mult_res_g_i = ~mult_res_g_i;
      mult_exp_b_i = ~mult_exp_b_i;
      mult_done_i  = ~mult_done_i;
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid_o, 1'b1);
      chk({tag, "_hold_pix_ready"}, pix_ready_o, 1'b0);
      chk({tag, "_hold_frac_r"}, out_frac_r_o, last.fr);
      chk({tag, "_hold_exp_b"}, out_exp_b_o, last.eb);
      chk({tag, "_hold_zero"}, out_zero_o, last.z);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk({tag, "_valid_dropped"}, out_valid_o, 1'b0);
    chk({tag, "_pix_ready_back"}, pix_ready_o, 1'b1);
  endtask

  initial begin
    int run_cycles;
    bit saw_valid;
    rst = 1'b1;
    pix_valid_i = 1'b0;
    pix_r_i = '0; pix_g_i = '0; pix_b_i = '0;
    mult_res_r_i = '0; mult_res_g_i = '0; mult_res_b_i = '0;
    mult_exp_r_i = '0; mult_exp_g_i = '0; mult_exp_b_i = '0;
    mult_done_i = 1'b0;
    out_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", pix_ready_o, 1'b0);
    chk("rst_mult_en", mult_en_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_zero", out_zero_o, 3'b000);
    chk("rst_data_r", mult_data_r_o, 10'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_pix_ready", pix_ready_o, 1'b1);

    // Normalisation with shared multiplier response
    drive_pixel(8'h80, 8'h01, 8'h03, 10'h264, 10'h264, 10'h264, -5'sd2, -5'sd2, -5'sd2, 1'b1);
    pulse_done(3);
    expect_beat("norm");
    chk("norm_exp_r_abs", out_exp_r_o, 6'sd5);
    chk("norm_exp_b_abs", out_exp_b_o, -6'sd1);
    finish_beat("norm", 0);

    // Zero green channel, done left high from the previous run
    drive_pixel(8'hFF, 8'h00, 8'h10, 10'h3FF, 10'h2AA, 10'h201, 5'sd15, -5'sd7, -5'sd16, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("stale_mult_en", mult_en_o, 1'b1);
      chk("stale_no_valid", out_valid_o, 1'b0);
    end
    pulse_done(2);
    expect_beat("zero");
    chk("zero_exp_r_max", out_exp_r_o, 6'sd22);
    finish_beat("bp", 10);

    // Next pixel accepted straight after the out handshake
    drive_pixel(8'h40, 8'h7F, 8'h01, 10'h155, 10'h0F0, 10'h3FF, 5'sd0, -5'sd16, 5'sd15, 1'b1);
    pulse_done(1);
    expect_beat("back2back");
    finish_beat("back2back", 0);

    // Watchdog: done never rises
    mult_done_i = 1'b0;
    drive_pixel(8'h05, 8'h00, 8'h00, 10'h111, 10'h111, 10'h111, 5'sd1, 5'sd1, 5'sd1, 1'b0);
    run_cycles = 1;
    saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid_o) saw_valid = 1'b1;
      if (!mult_en_o) break;
      run_cycles++;
    end
    chk("timeout_run_cycles", run_cycles, 255);
    chk("timeout_mult_en", mult_en_o, 1'b0);
    chk("timeout_err", err_o, 1'b1);
    chk("timeout_no_beat", saw_valid, 1'b0);
    chk("timeout_pix_ready", pix_ready_o, 1'b1);
    @(negedge clk);
    chk("err_sticky", err_o, 1'b1);

    // Reset in the middle of a run
    drive_pixel(8'h22, 8'h33, 8'h44, 10'h100, 10'h100, 10'h100, 5'sd0, 5'sd0, 5'sd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("midrun_mult_en", mult_en_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_mult_en", mult_en_o, 1'b0);
    chk("midrst_err", err_o, 1'b0);
    chk("midrst_pix_ready", pix_ready_o, 1'b0);
    chk("midrst_data_g", mult_data_g_o, 10'd0);
    chk("midrst_exp_r", out_exp_r_o, 6'sd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Normal pixel after reset
    drive_pixel(8'h02, 8'h80, 8'hC3, 10'h264, 10'h001, 10'h200, -5'sd2, 5'sd5, -5'sd1, 1'b1);
    pulse_done(2);
    expect_beat("post_rst");
    finish_beat("post_rst", 2);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
